// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one DRAM bridge between two requesters, one transaction in flight.
// Latency: accept T, command T+1, response one cycle after bridge completion; waiting requests stay pending until IDLE.
module bridge_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_r_wb,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data_w,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic              req1_r_wb,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data_w,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              C_in_valid,
    output logic              C_r_wb,
    output logic [ADDR_W-1:0] C_addr,
    output logic [DATA_W-1:0] C_data_w,
    input  logic              C_out_valid,
    input  logic [DATA_W-1:0] C_data_r
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic                grant;
    logic                winner;
    logic                accept;
    logic                lat_r_wb;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data_w;
    logic [DATA_W-1:0]   cap_data;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Gating with rst_n keeps ready low while reset is held.
    assign accept = rst_n && (state == IDLE) && (req0_valid || req1_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (C_out_valid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_r_wb   <= 1'b0;
            lat_addr   <= '0;
            lat_data_w <= '0;
            cap_data   <= '0;
        end else begin
            if (accept) begin
                grant      <= winner;
                last_grant <= winner;
                lat_r_wb   <= winner ? req1_r_wb   : req0_r_wb;
                lat_addr   <= winner ? req1_addr   : req0_addr;
                lat_data_w <= winner ? req1_data_w : req0_data_w;
            end
            if ((state == WAIT) && C_out_valid) begin
                cap_data <= lat_r_wb ? C_data_r : '0;
            end
        end
    end

    always_comb begin
        req0_ready = accept && !winner;
        req1_ready = accept && winner;
        C_in_valid = (state == ISSUE);
        C_r_wb     = C_in_valid && lat_r_wb;
        C_addr     = C_in_valid ? lat_addr   : '0;
        C_data_w   = C_in_valid ? lat_data_w : '0;
        rsp0_valid = (state == RESP) && !grant;
        rsp1_valid = (state == RESP) && grant;
        rsp0_data  = rsp0_valid ? cap_data : '0;
        rsp1_data  = rsp1_valid ? cap_data : '0;
    end

endmodule

// File: doc/bridge_arbiter.md
BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 8, user-ID / DRAM address width
- DATA_W, 64, DRAM record width
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 transaction request, held until accepted
- req0_r_wb  in  1  1 = read, 0 = write
- req0_addr  in  ADDR_W  target address
- req0_data_w  in  DATA_W  write data
- req0_ready  out  1  one-cycle accept pulse to requester 0
- rsp0_valid  out  1  one-cycle response pulse to requester 0
- rsp0_data  out  DATA_W  read data (0 for writes)
- req1_*, rsp1_*  same set as requester 0, for requester 1
- C_in_valid  out  1  one-cycle command pulse to the bridge
- C_r_wb  out  1  command type
- C_addr  out  ADDR_W  command address
- C_data_w  out  DATA_W  command write data
- C_out_valid  in  1  bridge completion pulse
- C_data_r  in  DATA_W  bridge read data, valid with C_out_valid

Function
REQ-003 The block SHALL share one bridge between two requesters, with exactly one transaction outstanding at any time.
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when either reqN_valid = 1
- ISSUE -> WAIT unconditionally
- WAIT -> RESP on C_out_valid = 1
- RESP -> IDLE unconditionally
REQ-005 Arbitration in IDLE SHALL be round-robin.
- A 1-bit last_grant register selects the winner when both requests are valid: the requester not equal to last_grant wins.
- A single valid requester wins regardless of last_grant.
- last_grant updates to the winner on acceptance.
REQ-006 On acceptance (IDLE and a winner exists) the block SHALL:
- pulse reqN_ready for the winner only, in that same cycle
- latch r_wb, addr and data_w into internal registers
- latch the grant index
REQ-007 In ISSUE, C_in_valid SHALL be 1 for exactly one cycle.
- C_r_wb, C_addr and C_data_w SHALL be driven from the latched registers.
- When C_in_valid = 0, C_r_wb, C_addr and C_data_w SHALL be 0.
REQ-008 In WAIT, on C_out_valid the block SHALL capture C_data_r if the latched r_wb = 1, and capture 0 otherwise.
REQ-009 In RESP, rspN_valid SHALL be 1 for exactly one cycle, for the granted requester only.
- rspN_data SHALL carry the captured data while rspN_valid = 1, and be 0 otherwise.
REQ-010 Latency SHALL be as follows, with acceptance at cycle T and the bridge answering k cycles after ISSUE (k >= 1):
- C_in_valid at T+1
- C_out_valid at T+1+k
- rspN_valid at T+2+k
- earliest next acceptance at T+3+k
REQ-011 C_out_valid outside WAIT SHALL be ignored, with no state change and no response.
REQ-012 reqN_valid arriving outside IDLE SHALL NOT be accepted; it is held pending and arbitrated on the next IDLE cycle.
REQ-013 A requester raising valid in the same cycle its previous rsp pulse is output SHALL be treated as a normal new request in the following IDLE.
REQ-014 Starvation bound: a continuously valid requester SHALL be accepted within 2 arbitration rounds.

Reset
REQ-015 rst_n = 0 SHALL asynchronously force:
- state = IDLE
- last_grant = 1, so requester 0 wins the first tie
- all latched registers = 0
- all outputs = 0
REQ-016 Reset during ISSUE, WAIT or RESP SHALL abort the transaction with no rsp pulse.
- A late C_out_valid after reset release SHALL be ignored per REQ-011.
REQ-017 The first acceptance after release SHALL occur no earlier than the first rising edge with rst_n = 1.

Verification
REQ-018 Single read: req0 read addr 0x05; bridge returns 0x1122334455667788 at k = 3 -> req0_ready at T, C_in_valid at T+1 with C_addr = 0x05 and C_r_wb = 1, rsp0_valid at T+5 with that data, rsp1_valid never set.
REQ-019 Write: req1 write addr 0xFF, data 0xA5A5...A5, k = 1 -> C_data_w = 0xA5A5...A5 and C_r_wb = 0 at T+1, rsp1_valid at T+3 with rsp1_data = 0.
REQ-020 Tie after reset: both requesters valid continuously for 4 transactions -> grant order 0, 1, 0, 1, with each requester seeing exactly two ready and two rsp pulses.
REQ-021 Spurious completion: C_out_valid pulsed while IDLE and while ISSUE -> no rsp pulse and no state change; the real completion later returns correctly.
REQ-022 Reset mid-op: rst_n low during WAIT for 2 cycles, bridge C_out_valid 3 cycles after release -> no rsp pulse, all outputs 0, and the next req0 accepted normally with grant to requester 0.
REQ-023 Back-to-back: req0 re-asserts valid the cycle rsp0_valid is high while req1 is idle -> next acceptance of req0 exactly one cycle later (T+3+k).
